// File: rtl/uart_pkg.sv
// Shared UART definitions: baud divisor tables for the 16x RX oversampler and
// the 1x TX bit timer (both for a 50 MHz clk), line levels and RX state encoding.
package uart_pkg;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    typedef logic [9:0]  rx_div_t;
    typedef logic [13:0] tx_div_t;

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_PARITY = 3'd3,
        RX_STOP   = 3'd4
    } rx_state_e;

    // 16x oversample terminal count: one tick every (value + 1) clocks
    function automatic rx_div_t rx_div(input logic [2:0] sel);
        case (sel)
            3'd0:    return rx_div_t'(650);
            3'd1:    return rx_div_t'(325);
            3'd2:    return rx_div_t'(162);
            3'd3:    return rx_div_t'(80);
            3'd4:    return rx_div_t'(53);
            3'd5:    return rx_div_t'(41);
            3'd6:    return rx_div_t'(26);
            default: return rx_div_t'(13);
        endcase
    endfunction

    // Full bit-time terminal count used by the matching transmitter
    function automatic tx_div_t tx_div(input logic [2:0] sel);
        case (sel)
            3'd0:    return tx_div_t'(10416);
            3'd1:    return tx_div_t'(5207);
            3'd2:    return tx_div_t'(2603);
            3'd3:    return tx_div_t'(1301);
            3'd4:    return tx_div_t'(867);
            3'd5:    return tx_div_t'(666);
            3'd6:    return tx_div_t'(433);
            default: return tx_div_t'(216);
        endcase
    endfunction

endpackage

// File: rtl/uart_rx_tick_gen.sv
// 16x oversample tick generator. The divisor is captured on clear_i (start
// detect) so baud_set may change freely while a frame is in flight.
module uart_rx_tick_gen
    import uart_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clear_i,
    input  logic       run_i,
    input  logic [2:0] baud_set_i,
    output logic       tick_o
);

    rx_div_t dr_q;
    rx_div_t div_cnt_q, div_cnt_d;

    assign tick_o = run_i && (div_cnt_q == dr_q);

    // Next divider count: cleared on start, parked at 0 while idle
    always_comb begin
        div_cnt_d = div_cnt_q + rx_div_t'(1);
        if (clear_i || !run_i || tick_o) begin
            div_cnt_d = '0;
        end
    end

    // Divisor latch and divider count registers
    always_ff @(posedge clk) begin
        if (reset) begin
            dr_q      <= rx_div(3'd0);
            div_cnt_q <= '0;
        end else begin
            if (clear_i) begin
                dr_q <= rx_div(baud_set_i);
            end
            div_cnt_q <= div_cnt_d;
        end
    end

endmodule

// File: rtl/uart_byte_rx_multibaud.sv
// 8N1 UART byte receiver, 16x oversampled, 3-sample majority vote per bit.
// Optional feature macro: UART_RX_PARITY_EN inserts a parity bit after bit 7
// and drives parity_err; without it parity_err is tied low.
module uart_byte_rx_multibaud
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 50_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       uart_rx,
    input  logic [2:0] baud_set,
    input  logic       parity_odd,
    output logic [7:0] data_byte,
    output logic       rx_done,
    output logic       frame_err,
    output logic       parity_err,
    output logic       uart_state
);

    // CLK_FREQ is informational; the divisor table is fixed for 50 MHz
    logic [31:0] unused_clk_freq;
    assign unused_clk_freq = CLK_FREQ;

    rx_state_e  state_q, state_d;
    logic       sync1_q, sync2_q, sync3_q;
    logic [3:0] tick_cnt_q;
    logic [2:0] bit_idx_q;
    logic       smp7_q, smp8_q;
    logic [7:0] shreg_q;
    logic [7:0] data_byte_q;
    logic       rx_done_q, frame_err_q;
    logic       tick, fall_edge, start_det, maj, mid_tick, end_tick;
    logic       run, shift_en, par_en, finish;

    assign fall_edge = ~sync2_q & sync3_q;
    assign start_det = (state_q == RX_IDLE) & fall_edge;
    assign mid_tick  = tick & (tick_cnt_q == 4'd9);
    assign end_tick  = tick & (tick_cnt_q == 4'd15);
    // Third vote is the live sample taken on the tick_cnt 9 tick
    assign maj = (smp7_q & smp8_q) | (smp7_q & sync2_q) | (smp8_q & sync2_q);

    uart_rx_tick_gen u_tick_gen (
        .clk        (clk),
        .reset      (reset),
        .clear_i    (start_det),
        .run_i      (run),
        .baud_set_i (baud_set),
        .tick_o     (tick)
    );

    // Two-flop synchronizer plus an edge-detect flop, idle-high reset
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            sync3_q <= 1'b1;
        end else begin
            sync1_q <= uart_rx;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) state_q <= RX_IDLE;
        else       state_q <= state_d;
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            RX_IDLE:   if (fall_edge) state_d = RX_START;
            RX_START: begin
                if (mid_tick && maj)  state_d = RX_IDLE;
                else if (end_tick)    state_d = RX_DATA;
            end
`ifdef UART_RX_PARITY_EN
            RX_DATA:   if (end_tick && bit_idx_q == 3'd7) state_d = RX_PARITY;
            RX_PARITY: if (end_tick) state_d = RX_STOP;
`else
            RX_DATA:   if (end_tick && bit_idx_q == 3'd7) state_d = RX_STOP;
`endif
            // Leaving at the stop-bit centre gives margin for back-to-back frames
            RX_STOP:   if (mid_tick) state_d = RX_IDLE;
            default:   state_d = RX_IDLE;
        endcase
    end

    // FSM output decode
    always_comb begin
        run        = (state_q != RX_IDLE);
        uart_state = run;
        shift_en   = (state_q == RX_DATA)   & mid_tick;
        par_en     = (state_q == RX_PARITY) & mid_tick;
        finish     = (state_q == RX_STOP)   & mid_tick;
    end

    // Bit timing, sampling, shift register and result registers
    always_ff @(posedge clk) begin
        if (reset) begin
            tick_cnt_q  <= '0;
            bit_idx_q   <= '0;
            smp7_q      <= 1'b1;
            smp8_q      <= 1'b1;
            shreg_q     <= '0;
            data_byte_q <= '0;
            rx_done_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            rx_done_q <= finish;
            if (state_q == RX_IDLE) begin
                tick_cnt_q <= '0;
                bit_idx_q  <= '0;
            end else if (tick) begin
                tick_cnt_q <= tick_cnt_q + 4'd1;
                if (tick_cnt_q == 4'd7) smp7_q <= sync2_q;
                if (tick_cnt_q == 4'd8) smp8_q <= sync2_q;
                if (end_tick && state_q == RX_DATA) bit_idx_q <= bit_idx_q + 3'd1;
            end
            if (shift_en) begin
                shreg_q <= {maj, shreg_q[7:1]};
            end
            if (finish) begin
                data_byte_q <= shreg_q;
                frame_err_q <= ~maj;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    logic par_bit_q, parity_err_q;

    // Capture the received parity bit and check it when the frame completes
    always_ff @(posedge clk) begin
        if (reset) begin
            par_bit_q    <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            if (par_en) par_bit_q <= maj;
            if (finish) parity_err_q <= (^shreg_q ^ parity_odd) != par_bit_q;
        end
    end
    assign parity_err = parity_err_q;
`else
    logic unused_parity;
    assign unused_parity = parity_odd ^ par_en;
    assign parity_err    = 1'b0;
`endif

    assign data_byte = data_byte_q;
    assign rx_done   = rx_done_q;
    assign frame_err = frame_err_q;

endmodule
